disparity_wta: RTL and testbench
================================

// Module: disparity_wta
//
// PURPOSE
//  Winner-take-all disparity selector. It sits directly downstream of the Hamming cost stage.
//  - Consumes one 32-bit Hamming cost per candidate disparity, d = 0..NDISP-1, for a pixel.
//  - Tracks the minimum cost and the second-lowest cost.
//  - Presents the winning disparity to the depth writer over a valid/ready handshake.
//
// PARAMETERS
//  COST_W  32  width of incoming Hamming cost (matches Hamming stage output)
//  NDISP   64  candidate disparities per pixel (>=1)
//  DISP_W  6   width of disparity index; 2**DISP_W >= NDISP
//
// PORTS
//  iClk         in   1       system clock, all logic on posedge
//  iReset       in   1       asynchronous, active-low reset
//  iCost        in   COST_W  Hamming cost for current disparity beat
//  iValid       in   1       iCost valid this cycle
//  oReady       out  1       block accepts a cost beat this cycle
//  iClear       in   1       synchronous abort of the current pixel
//  oValid       out  1       result registers hold a new, unconsumed result
//  iReady       in   1       consumer accepts the result
//  oDisp        out  DISP_W  winning disparity index
//  oMinCost     out  COST_W  winning (minimum) cost
//  oSecondCost  out  COST_W  second-lowest cost; all-ones if NDISP==1
//
// BEHAVIOUR
//  - Reset (iReset=0, async):
//    - State=ACCUM, beat counter d=0, working regs=0.
//    - oValid=0, oDisp=0, oMinCost=0, oSecondCost=0.
//    - oReady=1 once reset is released.
//  - States:
//    - ACCUM: oReady=1, oValid=0.
//    - HOLD: oReady=0, oValid=1.
//  - Beat accepted = ACCUM & iValid. Decode oReady from the state only; it never depends on iValid.
//  - Per accepted beat, working regs (min, second, best):
//    - d==0: min=iCost, best=0, second=all-ones.
//    - else if iCost < min: second=min, min=iCost, best=d.
//    - else if iCost < second: second=iCost.
//    - Ties use strict '<', so the lowest disparity wins.
//    - Equal costs still update second (iCost==min with d>0 -> second=iCost).
//    - Then d=d+1.
//  - Last beat (d==NDISP-1 accepted):
//    - Load oDisp/oMinCost/oSecondCost from the working-reg values computed on this same beat, including that beat's update.
//    - d=0, state goes to HOLD.
//    - oValid rises the cycle after the last beat (latency 1).
//  - HOLD: outputs are stable.
//    - On iReady=1, go to ACCUM next cycle; oValid=0 and oReady=1 the cycle after.
//    - No bypass: minimum pixel period is NDISP+1 cycles.
//  - Output registers change only on a last beat. Between results they keep the previous values.
//  - iClear (sync, highest priority):
//    - Sets state=ACCUM, d=0, oValid=0.
//    - Discards the beat on that cycle.
//    - Leaves output registers unchanged.
//  - NDISP==1: every accepted beat is both first and last.
//  - Cost arithmetic: unsigned compare over the full COST_W. No saturation; all-ones is a legal cost.
//  - Async reset mid-pixel aborts the pixel; the next accepted beat is treated as d=0.
//
// TESTING
//  1. Reset, NDISP=4, costs 9,3,7,3 -> oValid 1 cycle after beat 4; oDisp=1, oMinCost=3, oSecondCost=3.
//  2. Costs 5,4,3,2 descending -> oDisp=3, oMinCost=2, oSecondCost=3.
//  3. iValid gaps between beats; iReady held 0 for 5 cycles in HOLD ->
//     - outputs stable and oReady=0 throughout;
//     - after iReady=1, oReady=1 two cycles later.
//  4. iClear after 2 beats, then new pixel 8,1,6,2 -> oDisp=1, oMinCost=1; prior outputs unchanged until then.
//  5. iReset pulse low mid-pixel -> oValid=0 and all outputs 0 immediately; next 4 beats treated as a new pixel.
//  6. All costs 32'hFFFFFFFF -> oDisp=0, oMinCost=oSecondCost=32'hFFFFFFFF; NDISP=1 with cost 7 -> oDisp=0, oMinCost=7, oSecondCost=all-ones.

Source files
------------

// File: rtl/disparity_wta.sv
// Winner-take-all disparity selector: scans NDISP Hamming costs per pixel,
// keeps the lowest and second-lowest cost, and hands the winner to the
// depth writer over a valid/ready handshake.
module disparity_wta #(
  parameter int unsigned COST_W = 32,
  parameter int unsigned NDISP  = 64,
  parameter int unsigned DISP_W = 6
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic [COST_W-1:0] iCost,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iClear,
  output logic              oValid,
  input  logic              iReady,
  output logic [DISP_W-1:0] oDisp,
  output logic [COST_W-1:0] oMinCost,
  output logic [COST_W-1:0] oSecondCost
);

  localparam logic [DISP_W-1:0] LAST_IDX = DISP_W'(NDISP - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            state;
  logic [DISP_W-1:0] beatIdx;
  logic [COST_W-1:0] minCost;
  logic [COST_W-1:0] secondCost;
  logic [DISP_W-1:0] bestDisp;

  logic [COST_W-1:0] nextMin;
  logic [COST_W-1:0] nextSecond;
  logic [DISP_W-1:0] nextBest;
  logic              isLast;

  // Handshake flags are pure decodes of the state register.
  assign oReady = (state == ACCUM);
  assign oValid = (state == HOLD);
  assign isLast = (beatIdx == LAST_IDX);

  // Running min/second update for the current beat; the first beat seeds it.
  always_comb begin
    nextMin    = minCost;
    nextSecond = secondCost;
    nextBest   = bestDisp;
    if (beatIdx == '0) begin
      nextMin    = iCost;
      nextSecond = '1;
      nextBest   = '0;
    end else if (iCost < minCost) begin
      nextSecond = minCost;
      nextMin    = iCost;
      nextBest   = beatIdx;
    end else if (iCost < secondCost) begin
      nextSecond = iCost;
    end
  end

  // Beat accumulation, result capture on the last beat, and result hold.
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      state       <= ACCUM;
      beatIdx     <= '0;
      minCost     <= '0;
      secondCost  <= '0;
      bestDisp    <= '0;
      oDisp       <= '0;
      oMinCost    <= '0;
      oSecondCost <= '0;
    end else if (iClear) begin
      state   <= ACCUM;
      beatIdx <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (iValid) begin
            minCost    <= nextMin;
            secondCost <= nextSecond;
            bestDisp   <= nextBest;
            if (isLast) begin
              oDisp       <= nextBest;
              oMinCost    <= nextMin;
              oSecondCost <= nextSecond;
              beatIdx     <= '0;
              state       <= HOLD;
            end else begin
              beatIdx <= beatIdx + DISP_W'(1);
            end
          end
        end
        HOLD: begin
          if (iReady) begin
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_disparity_wta.sv
// Bench for disparity_wta: driver issues cost beats, a reference model
// predicts each pixel's result into a queue, and monitors compare on handshake.
module tb_disparity_wta;

  localparam int unsigned NDISP = 4;

  typedef struct {
    logic [1:0]  disp;
    logic [31:0] mn;
    logic [31:0] sec;
  } exp_t;

  logic        iClk;
  logic        iReset;
  logic [31:0] iCost;
  logic        iValid;
  logic        oReady;
  logic        iClear;
  logic        oValid;
  logic        iReady;
  logic [1:0]  oDisp;
  logic [31:0] oMinCost;
  logic [31:0] oSecondCost;

  logic [31:0] iCost1;
  logic        iValid1;
  logic        oReady1;
  logic        iClear1;
  logic        oValid1;
  logic        iReady1;
  logic [0:0]  oDisp1;
  logic [31:0] oMinCost1;
  logic [31:0] oSecondCost1;

  int checks = 0;
  int failures = 0;

  exp_t        expQ[$];
  exp_t        expQ1[$];
  logic [31:0] pix[$];

  logic holdOff = 1'b0;
  logic forceReady = 1'b0;

  disparity_wta #(.COST_W(32), .NDISP(NDISP), .DISP_W(2)) dut (
    .iClk(iClk), .iReset(iReset), .iCost(iCost), .iValid(iValid), .oReady(oReady),
    .iClear(iClear), .oValid(oValid), .iReady(iReady), .oDisp(oDisp),
    .oMinCost(oMinCost), .oSecondCost(oSecondCost)
  );

  disparity_wta #(.COST_W(32), .NDISP(1), .DISP_W(1)) dut1 (
    .iClk(iClk), .iReset(iReset), .iCost(iCost1), .iValid(iValid1), .oReady(oReady1),
    .iClear(iClear1), .oValid(oValid1), .iReady(iReady1), .oDisp(oDisp1),
    .oMinCost(oMinCost1), .oSecondCost(oSecondCost1)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reference: winner is the first index holding the minimum; second is the
  // next element of the sorted multiset (all-ones if there is only one).
  function automatic exp_t refModel(input logic [31:0] c[$]);
    exp_t        e;
    logic [31:0] s[$];
    s = c;
    s.sort();
    e.mn   = s[0];
    e.sec  = (s.size() > 1) ? s[1] : 32'hFFFF_FFFF;
    e.disp = 2'd0;
    for (int i = c.size() - 1; i >= 0; i--) begin
      if (c[i] == e.mn) e.disp = 2'(i);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] randCost();
    int m;
    m = $urandom_range(0, 9);
    if (m < 6) return 32'($urandom_range(0, 7));
    if (m < 8) return $urandom;
    return 32'hFFFF_FFFF - 32'($urandom_range(0, 1));
  endfunction

  // Random consumer backpressure, overridable for directed scenarios.
  initial begin
    iReady = 1'b0;
    forever begin
      @(posedge iClk);
      #1;
      iReady = holdOff ? 1'b0 : (forceReady ? 1'b1 : ($urandom_range(0, 2) != 0));
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic sendBeat(input logic [31:0] cost, input int gap);
    bit accepted;
    int tries;
    iValid = 1'b0;
    repeat (gap) tick();
    iValid   = 1'b1;
    iCost    = cost;
    accepted = 1'b0;
    tries    = 0;
    while (!accepted && tries < 200) begin
      @(negedge iClk);
      accepted = oReady;
      tick();
      tries++;
    end
    iValid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL beat_accept_timeout: oReady never seen, expected 1");
    end else begin
      pix.push_back(cost);
      if (pix.size() == NDISP) begin
        expQ.push_back(refModel(pix));
        pix.delete();
        check("valid_latency", 32'(oValid), 32'd1);
      end
    end
  endtask

  task automatic sendPixel(input logic [31:0] c0, input logic [31:0] c1,
                           input logic [31:0] c2, input logic [31:0] c3, input int maxGap);
    sendBeat(c0, $urandom_range(0, maxGap));
    sendBeat(c1, $urandom_range(0, maxGap));
    sendBeat(c2, $urandom_range(0, maxGap));
    sendBeat(c3, $urandom_range(0, maxGap));
  endtask

  task automatic drain();
    forceReady = 1'b1;
    repeat (8) tick();
    forceReady = 1'b0;
  endtask

  // Monitor for the NDISP=4 instance: handshake decode, output stability, scoreboard.
  logic [1:0]  prevDisp;
  logic [31:0] prevMin;
  logic [31:0] prevSec;
  logic        prevValid;
  exp_t        got;

  always @(negedge iClk) begin
    if (!iReset) begin
      prevValid = 1'b0;
    end else begin
      check("ready_vs_valid", 32'(oReady), 32'(!oValid));
      if (!(oValid && !prevValid)) begin
        check("out_stable_disp", 32'(oDisp), 32'(prevDisp));
        check("out_stable_min", oMinCost, prevMin);
        check("out_stable_sec", oSecondCost, prevSec);
      end
      if (oValid && iReady) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: disp %0d with empty queue", oDisp);
        end else begin
          got = expQ.pop_front();
          check("disp", 32'(oDisp), 32'(got.disp));
          check("min_cost", oMinCost, got.mn);
          check("second_cost", oSecondCost, got.sec);
        end
      end
      prevValid = oValid;
    end
    prevDisp = oDisp;
    prevMin  = oMinCost;
    prevSec  = oSecondCost;
  end

  // Monitor for the NDISP=1 instance.
  exp_t got1;
  always @(negedge iClk) begin
    if (iReset && oValid1 && iReady1) begin
      if (expQ1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result1: min %0h with empty queue", oMinCost1);
      end else begin
        got1 = expQ1.pop_front();
        check("disp1", 32'(oDisp1), 32'(got1.disp));
        check("min_cost1", oMinCost1, got1.mn);
        check("second_cost1", oSecondCost1, got1.sec);
      end
    end
  end

  task automatic sendBeat1(input logic [31:0] cost);
    bit accepted;
    int tries;
    exp_t e;
    iValid1  = 1'b1;
    iCost1   = cost;
    accepted = 1'b0;
    tries    = 0;
    while (!accepted && tries < 50) begin
      @(negedge iClk);
      accepted = oReady1;
      tick();
      tries++;
    end
    iValid1 = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL beat_accept_timeout1: oReady1 never seen, expected 1");
    end else begin
      e.disp = 2'd0;
      e.mn   = cost;
      e.sec  = 32'hFFFF_FFFF;
      expQ1.push_back(e);
    end
  endtask

  int waitCnt;
  bit sawReady;

  initial begin
    iReset  = 1'b0;
    iCost   = '0;
    iValid  = 1'b0;
    iClear  = 1'b0;
    iCost1  = '0;
    iValid1 = 1'b0;
    iClear1 = 1'b0;
    iReady1 = 1'b1;
    #12;
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_disp", 32'(oDisp), 32'd0);
    check("rst_min", oMinCost, 32'd0);
    check("rst_sec", oSecondCost, 32'd0);
    @(posedge iClk);
    #1;
    iReset = 1'b1;
    #1;
    check("rst_ready", 32'(oReady), 32'd1);

    // Directed pixels: tie on minimum, then descending costs.
    sendPixel(32'd9, 32'd3, 32'd7, 32'd3, 0);
    drain();
    sendPixel(32'd5, 32'd4, 32'd3, 32'd2, 0);
    drain();

    // Gaps between beats, consumer stalls for 5 cycles in HOLD.
    holdOff = 1'b1;
    sendPixel(32'd20, 32'd11, 32'd11, 32'd30, 3);
    repeat (5) begin
      tick();
      check("hold_ready_low", 32'(oReady), 32'd0);
    end
    check("hold_valid_high", 32'(oValid), 32'd1);
    holdOff    = 1'b0;
    forceReady = 1'b1;
    sawReady   = 1'b0;
    waitCnt    = 0;
    while (!sawReady && waitCnt < 4) begin
      @(negedge iClk);
      sawReady = oReady;
      waitCnt++;
    end
    check("release_ready", 32'(sawReady), 32'd1);
    forceReady = 1'b0;
    drain();

    // Abort after two beats; the cost offered with the clear is discarded.
    sendBeat(32'd0, 0);
    sendBeat(32'd0, 1);
    iClear = 1'b1;
    iValid = 1'b1;
    iCost  = 32'd0;
    tick();
    iClear = 1'b0;
    iValid = 1'b0;
    pix.delete();
    repeat (2) tick();
    sendPixel(32'd8, 32'd1, 32'd6, 32'd2, 1);
    drain();

    // Async reset mid-pixel clears outputs immediately.
    sendBeat(32'd1, 0);
    sendBeat(32'd2, 0);
    #2;
    iReset = 1'b0;
    #1;
    check("midrst_valid", 32'(oValid), 32'd0);
    check("midrst_disp", 32'(oDisp), 32'd0);
    check("midrst_min", oMinCost, 32'd0);
    check("midrst_sec", oSecondCost, 32'd0);
    tick();
    iReset = 1'b1;
    pix.delete();
    sendPixel(32'd6, 32'd6, 32'd5, 32'd9, 1);
    drain();

    // All-ones costs are legal and the lowest index wins the tie.
    sendPixel(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    drain();

    // Randomized pixels with random gaps and backpressure.
    for (int p = 0; p < 40; p++) begin
      sendPixel(randCost(), randCost(), randCost(), randCost(), 2);
    end
    drain();

    // Single-disparity instance: every beat is first and last.
    sendBeat1(32'd7);
    for (int k = 0; k < 8; k++) sendBeat1(randCost());
    sendBeat1(32'hFFFF_FFFF);
    repeat (4) tick();

    check("queue_empty", 32'(expQ.size()), 32'd0);
    check("queue1_empty", 32'(expQ1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
